ternary_neuron_acc: RTL and testbench

TERNARY_NEURON_ACC -- requirements
Module: ternary_neuron_acc

---
 rtl/tnn_pkg.sv | 8 +
 rtl/tna_sat_add.sv | 17 +
 rtl/ternary_neuron_acc.sv | 68 ++++++
 tb/tb_ternary_neuron_acc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// tnn_pkg: shared activation encodings, FSM state type and beat-count width for the ternary neuron accumulator.
package tnn_pkg;
   localparam logic [1:0] ACT_POS  = 2'b01;
   localparam logic [1:0] ACT_ZERO = 2'b00;
   localparam logic [1:0] ACT_NEG  = 2'b11;
   localparam int BEAT_W = 8;
   typedef enum logic {ST_ACC, ST_OUT} state_t;
endpackage

// File: rtl/tna_sat_add.sv
// tna_sat_add: signed W-bit + 5-bit adder; saturates when TNA_SATURATE_EN is defined, otherwise wraps modulo 2^W.
module tna_sat_add #(
   parameter int W = 8
) (
   input  logic signed [W-1:0] a,
   input  logic signed [4:0]   d,
   output logic signed [W-1:0] y
);
`ifdef TNA_SATURATE_EN
   logic signed [W:0] s;
   assign s = (W+1)'(a) + (W+1)'(d);
   // A one-bit-wider sum disagreeing in its top two bits means the W-bit result overflowed.
   assign y = (s[W] ^ s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
`else
   assign y = a + W'(d);
`endif
endmodule

// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates pos_cnt-neg_cnt per beat over a window and emits a ternary activation.
// Define TNA_SATURATE_EN for a saturating accumulator; default build wraps.
module ternary_neuron_acc
   import tnn_pkg::*;
#(
   parameter int ACC_W  = 8,
   parameter int THR_HI = 3,
   parameter int THR_LO = -3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              pos_cnt,
   input  logic [3:0]              neg_cnt,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_act,
   output logic signed [ACC_W-1:0] out_acc,
   output logic [BEAT_W-1:0]       out_beats
);
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(THR_HI);
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(THR_LO);
   if (THR_LO > THR_HI) begin : g_thr_chk
      $error("ternary_neuron_acc: THR_LO must not exceed THR_HI");
   end
   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic signed [4:0]       delta;
   logic [BEAT_W-1:0]       beats;
   logic [BEAT_W-1:0]       beats_nx;
   logic [1:0]              act_nx;
   assign delta    = $signed({1'b0, pos_cnt} - {1'b0, neg_cnt});
   assign beats_nx = (beats == '1) ? beats : beats + BEAT_W'(1);
   assign act_nx   = (sum > HI) ? ACT_POS : (sum < LO) ? ACT_NEG : ACT_ZERO;
   assign in_ready = !rst && state == ST_ACC;
   tna_sat_add #(.W(ACC_W)) u_add (.a(acc), .d(delta), .y(sum));
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACC;
         acc       <= '0;
         beats     <= '0;
         out_valid <= 1'b0;
         out_act   <= ACT_ZERO;
         out_acc   <= '0;
         out_beats <= '0;
      end else if (state == ST_ACC) begin
         if (in_valid) begin
            acc   <= sum;
            beats <= beats_nx;
            if (in_last) begin
               state     <= ST_OUT;
               out_valid <= 1'b1;
               out_acc   <= sum;
               out_beats <= beats_nx;
               out_act   <= act_nx;
            end
         end
      end else if (out_ready) begin
         state     <= ST_ACC;
         out_valid <= 1'b0;
         acc       <= '0;
         beats     <= '0;
      end
   end
endmodule

// File: tb/tb_ternary_neuron_acc.sv
// tb_ternary_neuron_acc: directed windows with literal expectations plus a per-cycle reference model of the accumulator.
module tb_ternary_neuron_acc;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        pos_cnt = '0;
   logic [3:0]        neg_cnt = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [1:0]        out_act;
   logic signed [7:0] out_acc;
   logic [7:0]        out_beats;
   int checks = 0;
   int passes = 0;
   bit started = 0;
   int m_acc = 0, m_beats = 0, o_acc = 0, o_beats = 0;
   bit m_out = 0;

   ternary_neuron_acc #(.ACC_W(8), .THR_HI(3), .THR_LO(-3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
      .out_acc(out_acc), .out_beats(out_beats)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   function automatic int fold(input int v);
`ifdef TNA_SATURATE_EN
      return v > 127 ? 127 : v < -128 ? -128 : v;
`else
      int m;
      m = ((v % 256) + 256) % 256;
      return m >= 128 ? m - 256 : m;
`endif
   endfunction

   function automatic int act_of(input int v);
      return v > 3 ? 1 : v < -3 ? 3 : 0;
   endfunction

   // Reference model: window sum folded per beat, result latched on the last beat.
   always @(posedge clk) begin
      if (rst) begin
         started = 1;
         m_out = 0; m_acc = 0; m_beats = 0; o_acc = 0; o_beats = 0;
      end else if (!m_out && in_valid) begin
         m_acc = fold(m_acc + int'(pos_cnt) - int'(neg_cnt));
         m_beats = m_beats < 255 ? m_beats + 1 : 255;
         if (in_last) begin
            m_out = 1; o_acc = m_acc; o_beats = m_beats;
         end
      end else if (m_out && out_ready) begin
         m_out = 0; m_acc = 0; m_beats = 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model in_ready", int'(in_ready), int'(!rst && !m_out));
         chk("model out_valid", int'(out_valid), int'(m_out));
         if (m_out) begin
            chk("model out_acc", int'(out_acc), o_acc);
            chk("model out_act", int'(out_act), act_of(o_acc));
            chk("model out_beats", int'(out_beats), o_beats);
         end
      end
   end

   task automatic beat(input int p, input int n, input bit l);
      in_valid = 1'b1; pos_cnt = 4'(p); neg_cnt = 4'(n); in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic take(input string name, input int acc, input int act, input int beats);
      chk({name, " valid"}, int'(out_valid), 1);
      chk({name, " acc"}, int'(out_acc), acc);
      chk({name, " act"}, int'(out_act), act);
      chk({name, " beats"}, int'(out_beats), beats);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " released"}, int'(out_valid), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", int'(in_ready), 0);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst out_acc", int'(out_acc), 0);
      chk("rst out_act", int'(out_act), 0);
      chk("rst out_beats", int'(out_beats), 0);
      rst = 1'b0;
      #1 chk("post rst in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      beat(7, 2, 1);
      take("single", 5, 1, 1);
      out_ready = 1'b1;
      beat(2, 5, 0); beat(1, 4, 0); beat(0, 3, 1);
      take("negative", -9, 3, 3);
      beat(3, 0, 1);  take("thr +3", 3, 0, 1);
      beat(0, 3, 1);  take("thr -3", -3, 0, 1);
      beat(2, 0, 0); beat(2, 0, 1); take("thr +4", 4, 1, 2);
      beat(12, 15, 0); beat(0, 1, 1); take("thr -4", -4, 3, 2);
      beat(4, 0, 1);
      in_valid = 1'b1; pos_cnt = 4'd5; neg_cnt = 4'd0; in_last = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp in_ready", int'(in_ready), 0);
         chk("bp out_valid", int'(out_valid), 1);
         chk("bp out_acc", int'(out_acc), 4);
         chk("bp out_beats", int'(out_beats), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp handshake in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      take("after bp", 5, 1, 1);
      repeat (29) beat(15, 0, 0);
      beat(15, 0, 1);
`ifdef TNA_SATURATE_EN
      take("overflow", 127, 1, 30);
`else
      take("overflow", -62, 3, 30);
`endif
      beat(5, 0, 0); beat(5, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid rst in_ready", int'(in_ready), 0);
      chk("mid rst out_valid", int'(out_valid), 0);
      rst = 1'b0;
      beat(1, 0, 1);
      take("after rst", 1, 0, 1);
      repeat (259) beat(0, 0, 0);
      beat(0, 0, 1);
      take("beat sat", 0, 0, 255);
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
